lc3_fetch_prefetch: RTL and testbench
=====================================

# lc3_fetch_prefetch

Instruction fetch stage for the LC3 pipeline. It sits between instruction memory and decode. It keeps the fetch PC, issues one instruction-memory read at a time, and buffers the returned words with their PCs in a small queue. It presents the queue head to decode with a valid/ready handshake and flushes on taken branches.

## Interface
Parameters:
- `DEPTH`, default 2: prefetch queue entries (power of two, ≥2).
- `RESET_PC`, default 16'h3000: fetch PC after reset.

Ports (one clock; reset is asynchronous, active-high):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable_fetch`  in  1  permits new memory requests; does not affect the queue or responses.
- `br_taken`  in  1  redirect; sampled at `clock`.
- `taddr`  in  16  redirect target PC.
- `imem_rd`  out  1  registered one-cycle read strobe.
- `imem_addr`  out  16  registered read address; held between strobes.
- `imem_rdata`  in  16  read data; valid when `imem_valid` is 1.
- `imem_valid`  in  1  response strobe, arriving 1 or more cycles after `imem_rd`.
- `instr_valid`  out  1  queue not empty.
- `instr_ready`  in  1  decode accepts the head.
- `instr_dout`  out  16  head instruction; 0 when empty.
- `pc`  out  16  head PC; 0 when empty.
- `npc`  out  16  `pc`+1 (mod 2^16); 0 when empty.

## Operation
- State register `fpc`: 16 bits, the next address to request.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; `req_pc` holds its address.
  - DROP: one request outstanding, but a redirect made it stale.
- IDLE transitions:
  - If `br_taken`: `fpc`←`taddr`; no request issued this cycle.
  - Else if `enable_fetch` and count < DEPTH: `imem_rd`←1, `imem_addr`←`fpc`, `req_pc`←`fpc`, `fpc`←`fpc`+1, go to WAIT.
- WAIT transitions:
  - `imem_valid` and no `br_taken`: push {`req_pc`, `imem_rdata`}, go to IDLE.
  - `imem_valid` and `br_taken` together: discard the data, `fpc`←`taddr`, go to IDLE.
  - `br_taken` without `imem_valid`: `fpc`←`taddr`, go to DROP.
- DROP transitions:
  - `imem_valid`: discard the data, go to IDLE.
  - `br_taken` again: `fpc`←`taddr`, stay in DROP.
- Any `imem_valid` seen in IDLE is ignored. This is a protocol error; it is flagged by an assertion only.
- Queue:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap.
  - A separate count runs 0..DEPTH.
  - Pop when `instr_valid` and `instr_ready`.
  - Push and pop in the same cycle leave the count unchanged.
- Overflow is impossible. A request is only issued when count < DEPTH with nothing outstanding, so a push always finds space.
- Redirect: `br_taken` empties the queue (pointers and count go to 0) in the same edge. Any pop in that cycle is ignored.
  - Priority order: `br_taken` > push > pop.
- `fpc` and `npc` arithmetic is 16-bit modular: 16'hFFFF + 1 = 16'h0000.
- All queue outputs are combinational from the head entry. `imem_rd` and `imem_addr` are registered.

## Timing
- Reset values:
  - `imem_rd`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr_dout`=0, `pc`=0, `npc`=0.
  - `fpc`=`RESET_PC`, FSM in IDLE, queue empty.
- Reset asserted mid-request returns to IDLE with the queue empty. A later `imem_valid` is then ignored.
- Request to visible instruction:
  - `imem_valid` sampled at edge N.
  - The entry is visible (`instr_valid`=1) after edge N.
  - It can be popped by `instr_ready` at edge N+1.
- The earliest next `imem_rd` follows the edge after the push. Issue throughput is one request per (memory latency + 1) cycles.
- `imem_rd` is high for exactly one cycle per request.
- `br_taken` at edge N causes all of the following:
  - `instr_valid`=0 after edge N.
  - The first request to `taddr` at edge N+1 or later, once nothing is outstanding.
- Holding `enable_fetch` low blocks only new requests. An outstanding response is still pushed, and decode can still drain the queue.

## Test plan
- Reset, 1-cycle memory latency, `instr_ready`=1:
  - `imem_addr` sequence is 3000, 3001, 3002.
  - `pc`/`npc` read 3000/3001, then 3001/3002.
  - `instr_dout` matches the memory words in order.
- `instr_ready`=0 with DEPTH=2:
  - Exactly two requests (3000, 3001), after which `imem_rd` stays 0.
  - Raising `instr_ready` drains 3000 then 3001, and fetching resumes at 3002.
- `br_taken` with `taddr`=16'h3050 while in WAIT (latency 3):
  - The stale response is discarded and the queue is empty.
  - The next `imem_addr` is 3050, and the head `pc` becomes 3050.
- `br_taken` in the same cycle as `imem_valid`:
  - The data is not pushed.
  - The next request goes to `taddr`, with no DROP state entered.
- Wrap-around at `fpc`=16'hFFFF:
  - The request is FFFF, the next request is 0000.
  - Head `npc` reads 0000.
- Assert `reset` while in WAIT and pulse `imem_valid` afterwards:
  - The queue stays empty.
  - The first request after reset goes to 3000.

Source files
------------

// File: rtl/lc3_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : lc3_fetch_prefetch
// Purpose  : LC3 instruction fetch stage. It keeps the fetch PC and issues
//            one instruction-memory read at a time. Returned words are
//            buffered with their PCs in a small circular prefetch queue.
//            The queue head is presented to decode through a valid/ready
//            handshake. A taken branch redirects the fetch PC and flushes
//            the queue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        prefetch queue entries (power of two, >= 2)
//   RESET_PC     fetch PC after reset
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   enable_fetch in   permits new memory requests
//   br_taken     in   redirect strobe
//   taddr        in   redirect target PC
//   imem_rd      out  registered one-cycle read strobe
//   imem_addr    out  registered read address, held between strobes
//   imem_rdata   in   read data, qualified by imem_valid
//   imem_valid   in   read response strobe
//   instr_valid  out  queue not empty
//   instr_ready  in   decode accepts the head entry
//   instr_dout   out  head instruction (0 when empty)
//   pc           out  head PC (0 when empty)
//   npc          out  head PC + 1 (0 when empty)
// ============================================================================
module lc3_fetch_prefetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_dout,
  output logic [15:0] pc,
  output logic [15:0] npc
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding
    S_WAIT = 2'd1,  // one live request outstanding
    S_DROP = 2'd2   // one request outstanding, made stale by a redirect
  } state_t;

  state_t            state_q;
  logic [15:0]       fpc_q;
  logic [15:0]       req_pc_q;
  logic [15:0]       imem_addr_q;
  logic              imem_rd_q;
  // Set once a request has been issued since reset; a response in IDLE is
  // only a protocol error if some request could have produced it.
  logic              armed_q;

  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [15:0]       q_pc_mem   [DEPTH];
  logic [15:0]       q_data_mem [DEPTH];

  logic              head_valid;
  logic              do_push;
  logic              do_pop;
  logic              can_issue;

  assign head_valid = (count_q != '0);
  // A response is only accepted for a live request and loses to a redirect.
  assign do_push    = (state_q == S_WAIT) && imem_valid && !br_taken;
  // A redirect flushes the queue, so a simultaneous pop is meaningless.
  assign do_pop     = head_valid && instr_ready && !br_taken;
  // Issuing only with a free slot and nothing outstanding guarantees the
  // eventual push always finds space.
  assign can_issue  = enable_fetch && (count_q < C_DEPTH);

  // Fetch FSM, request outputs and queue bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fpc_q       <= RESET_PC;
      req_pc_q    <= '0;
      imem_addr_q <= RESET_PC;
      imem_rd_q   <= 1'b0;
      armed_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      imem_rd_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (br_taken) begin
            fpc_q <= taddr;
          end else if (can_issue) begin
            imem_rd_q   <= 1'b1;
            imem_addr_q <= fpc_q;
            req_pc_q    <= fpc_q;
            fpc_q       <= fpc_q + 16'd1;
            armed_q     <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            // Data is pushed by the queue logic unless a redirect kills it.
            if (br_taken) begin
              fpc_q <= taddr;
            end
            state_q <= S_IDLE;
          end else if (br_taken) begin
            fpc_q   <= taddr;
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (br_taken) begin
            fpc_q <= taddr;
          end
          if (imem_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (br_taken) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + C_ONE;
          2'b01:   count_q <= count_q - C_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage carries no reset; entries are only visible via count_q.
  always_ff @(posedge clock) begin
    if (do_push) begin
      q_pc_mem[wr_ptr_q]   <= req_pc_q;
      q_data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_rd     = imem_rd_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = head_valid;
  assign instr_dout  = head_valid ? q_data_mem[rd_ptr_q] : 16'h0000;
  assign pc          = head_valid ? q_pc_mem[rd_ptr_q]   : 16'h0000;
  assign npc         = head_valid ? (q_pc_mem[rd_ptr_q] + 16'd1) : 16'h0000;

`ifndef SYNTHESIS
  // A response while idle has no request to belong to.
  a_no_resp_when_idle: assert property (
    @(posedge clock) disable iff (reset)
      !((state_q == S_IDLE) && armed_q && imem_valid)
  ) else $error("lc3_fetch_prefetch: imem_valid with no request outstanding");
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_fetch_prefetch
// Purpose  : Self-checking bench for lc3_fetch_prefetch. A transaction-level
//            model of the fetch stage (request queue, outstanding/stale flags)
//            is compared against the DUT every cycle, and directed scenarios
//            pin the model with literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_fetch_prefetch;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = 16'h0000;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_dout;
  logic [15:0] pc;
  logic [15:0] npc;

  lc3_fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_fetch (enable_fetch),
    .br_taken     (br_taken),
    .taddr        (taddr),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_dout   (instr_dout),
    .pc           (pc),
    .npc          (npc)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mw(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] d;
  } ent_t;

  // ---------------- instruction memory ----------------
  // lat = number of cycles between the read-strobe cycle and the response cycle
  int          lat = 0;
  bit          keep_pend = 1'b0;   // let a pending response survive reset
  bit          pend = 1'b0;
  int          wait_n = 0;
  logic [15:0] paddr = 16'h0000;

  always begin
    @(posedge clock);
    #1;
    imem_valid = 1'b0;
    imem_rdata = 16'hBAD0;
    if (reset && !keep_pend) begin
      pend = 1'b0;
    end else if (imem_rd) begin
      pend   = 1'b1;
      wait_n = lat;
      paddr  = imem_addr;
    end else if (pend && wait_n > 0) begin
      wait_n--;
    end
    if (pend && wait_n == 0) begin
      imem_valid = 1'b1;
      imem_rdata = mw(paddr);
      pend       = 1'b0;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  ent_t        mq[$];
  logic [15:0] m_fpc  = RESET_PC;
  logic [15:0] m_req  = 16'h0000;
  logic [15:0] m_addr = RESET_PC;
  bit          m_out = 1'b0, m_stale = 1'b0, m_rd = 1'b0;
  bit          m_can, m_pop;
  logic [15:0] alog[$];   // every address the DUT strobed
  ent_t        acc[$];    // every head the DUT handed to decode

  always begin
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_fpc = RESET_PC; m_addr = RESET_PC;
      m_out = 1'b0; m_stale = 1'b0; m_rd = 1'b0;
    end else begin
      if (instr_valid && instr_ready && !br_taken)
        acc.push_back('{pc: pc, npc: npc, d: instr_dout});
      m_can = !m_out && !br_taken && enable_fetch && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && instr_ready && !br_taken;
      if (m_pop) void'(mq.pop_front());
      m_rd = 1'b0;
      if (m_out && imem_valid) begin
        if (!m_stale && !br_taken)
          mq.push_back('{pc: m_req, npc: m_req + 16'd1, d: imem_rdata});
        m_out = 1'b0;
        m_stale = 1'b0;
      end
      if (br_taken) begin
        mq.delete();
        m_fpc = taddr;
        if (m_out) m_stale = 1'b1;
      end
      if (m_can) begin
        m_rd = 1'b1; m_addr = m_fpc; m_req = m_fpc;
        m_fpc = m_fpc + 16'd1;
        m_out = 1'b1; m_stale = 1'b0;
      end
    end
    #1;
    if (imem_rd) alog.push_back(imem_addr);
    if (!reset) begin
      chk("cyc_imem_rd",   {31'd0, imem_rd}, {31'd0, m_rd});
      chk("cyc_imem_addr", {16'd0, imem_addr}, {16'd0, m_addr});
      chk("cyc_valid",     {31'd0, instr_valid}, {31'd0, (mq.size() > 0)});
      chk("cyc_dout", {16'd0, instr_dout}, {16'd0, (mq.size() > 0) ? mq[0].d   : 16'h0000});
      chk("cyc_pc",   {16'd0, pc},         {16'd0, (mq.size() > 0) ? mq[0].pc  : 16'h0000});
      chk("cyc_npc",  {16'd0, npc},        {16'd0, (mq.size() > 0) ? mq[0].npc : 16'h0000});
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; br_taken = 1'b0; enable_fetch = 1'b0; instr_ready = 1'b0;
    repeat (2) tick();
    alog.delete(); acc.delete();
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (alog.size() < n && k < 100) begin tick(); k++; end
    chk(name, {31'd0, (alog.size() >= n)}, 32'd1);
  endtask

  task automatic wait_acc(input int n, input string name);
    int k = 0;
    while (acc.size() < n && k < 100) begin tick(); k++; end
    chk(name, {31'd0, (acc.size() >= n)}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid && k < 100) begin tick(); k++; end
    chk(name, {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) tick();
    chk("rst_imem_rd",   {31'd0, imem_rd}, 32'd0);
    chk("rst_imem_addr", {16'd0, imem_addr}, 32'h3000);
    chk("rst_valid",     {31'd0, instr_valid}, 32'd0);
    chk("rst_dout",      {16'd0, instr_dout}, 32'd0);
    chk("rst_pc",        {16'd0, pc}, 32'd0);
    chk("rst_npc",       {16'd0, npc}, 32'd0);
    reset = 1'b0;

    // 1) streaming with 1-cycle memory, decode always ready
    lat = 0; enable_fetch = 1'b1; instr_ready = 1'b1;
    wait_log(3, "t1_timeout_req");
    wait_acc(2, "t1_timeout_acc");
    chk("t1_addr0", {16'd0, alog[0]}, 32'h3000);
    chk("t1_addr1", {16'd0, alog[1]}, 32'h3001);
    chk("t1_addr2", {16'd0, alog[2]}, 32'h3002);
    chk("t1_pc0",   {16'd0, acc[0].pc},  32'h3000);
    chk("t1_npc0",  {16'd0, acc[0].npc}, 32'h3001);
    chk("t1_d0",    {16'd0, acc[0].d},   {16'd0, mw(16'h3000)});
    chk("t1_pc1",   {16'd0, acc[1].pc},  32'h3001);
    chk("t1_npc1",  {16'd0, acc[1].npc}, 32'h3002);
    chk("t1_d1",    {16'd0, acc[1].d},   {16'd0, mw(16'h3001)});

    // 2) decode stalled: queue fills, fetch stops, then drains and resumes
    do_reset();
    lat = 1; enable_fetch = 1'b1; instr_ready = 1'b0;
    repeat (20) tick();
    chk("t2_nreq",  alog.size(), 32'd2);
    chk("t2_addr0", {16'd0, alog[0]}, 32'h3000);
    chk("t2_addr1", {16'd0, alog[1]}, 32'h3001);
    chk("t2_rd_idle", {31'd0, imem_rd}, 32'd0);
    chk("t2_head_pc", {16'd0, pc}, 32'h3000);
    instr_ready = 1'b1;
    wait_acc(2, "t2_timeout_acc");
    wait_log(3, "t2_timeout_req");
    chk("t2_pop0",  {16'd0, acc[0].pc}, 32'h3000);
    chk("t2_pop1",  {16'd0, acc[1].pc}, 32'h3001);
    chk("t2_addr2", {16'd0, alog[2]}, 32'h3002);

    // 3) redirect while a request is outstanding (stale response dropped)
    do_reset();
    lat = 3; enable_fetch = 1'b1; instr_ready = 1'b0;
    wait_log(2, "t3_timeout_req");
    br_taken = 1'b1; taddr = 16'h3050;
    tick();
    br_taken = 1'b0;
    chk("t3_flush_valid", {31'd0, instr_valid}, 32'd0);
    repeat (5) tick();
    chk("t3_stale_dropped", {31'd0, instr_valid}, 32'd0);
    wait_log(3, "t3_timeout_req2");
    chk("t3_addr_redir", {16'd0, alog[2]}, 32'h3050);
    wait_valid("t3_timeout_valid");
    chk("t3_head_pc",   {16'd0, pc}, 32'h3050);
    chk("t3_head_dout", {16'd0, instr_dout}, {16'd0, mw(16'h3050)});

    // 4) redirect in the same cycle as the response
    do_reset();
    lat = 2; enable_fetch = 1'b1; instr_ready = 1'b1;
    k = 0;
    while (!imem_valid && k < 100) begin tick(); k++; end
    chk("t4_timeout_resp", {31'd0, imem_valid}, 32'd1);
    br_taken = 1'b1; taddr = 16'h3100;
    tick();
    br_taken = 1'b0;
    chk("t4_not_pushed", {31'd0, instr_valid}, 32'd0);
    chk("t4_rd_gap",     {31'd0, imem_rd}, 32'd0);
    tick();
    chk("t4_rd_next",   {31'd0, imem_rd}, 32'd1);
    chk("t4_addr_next", {16'd0, imem_addr}, 32'h3100);

    // 5) fetch PC wrap-around
    do_reset();
    lat = 0; enable_fetch = 1'b1; instr_ready = 1'b0;
    br_taken = 1'b1; taddr = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    wait_log(2, "t5_timeout_req");
    chk("t5_addr0", {16'd0, alog[0]}, 32'hFFFF);
    chk("t5_addr1", {16'd0, alog[1]}, 32'h0000);
    wait_valid("t5_timeout_valid");
    chk("t5_pc",  {16'd0, pc},  32'hFFFF);
    chk("t5_npc", {16'd0, npc}, 32'h0000);

    // 6) reset while waiting; the late response must be ignored
    do_reset();
    lat = 3; enable_fetch = 1'b1; instr_ready = 1'b1;
    wait_log(1, "t6_timeout_req");
    keep_pend = 1'b1; reset = 1'b1; enable_fetch = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("t6_empty", {31'd0, instr_valid}, 32'd0);
    chk("t6_no_req", alog.size(), 32'd1);
    keep_pend = 1'b0;
    alog.delete();
    enable_fetch = 1'b1;
    wait_log(1, "t6_timeout_req2");
    chk("t6_addr0", {16'd0, alog[0]}, 32'h3000);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
